// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM state
// encoding and the captured-request record.
package alu_arbiter_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } req_t;

    // Only add/sub can report overflow; logic ops clear the flag.
    function automatic logic is_arith(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// 4-bit ALU: add, sub, nand, xor. The overflow output always reflects the
// adder path, so the consumer masks it for the logic opcodes.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] i_op,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_y,
    output logic       o_ovf
);

    logic [4:0] w_add;
    logic [4:0] w_sub;

    // Sign-extended add/sub so overflow is a disagreement of the top two bits.
    always_comb begin
        w_add = {i_a[3], i_a} + {i_b[3], i_b};
        w_sub = {i_a[3], i_a} - {i_b[3], i_b};
        o_y   = w_add[3:0];
        o_ovf = w_add[4] ^ w_add[3];
        case (i_op)
            OP_ADD: begin
                o_y   = w_add[3:0];
                o_ovf = w_add[4] ^ w_add[3];
            end
            OP_SUB: begin
                o_y   = w_sub[3:0];
                o_ovf = w_sub[4] ^ w_sub[3];
            end
            OP_NAND: o_y = ~(i_a & i_b);
            default: o_y = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto the shared 4-bit ALU and returns a
// registered result with a per-requester done pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no operation in flight; capture a winner when any req is high
// ST_EXEC | winner's gnt high; ALU runs from the operand registers
// ST_RESP | winner's done high, res/err valid; may capture the next winner
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [3:0]       a0,
    input  logic [3:0]       b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [3:0]       a1,
    input  logic [3:0]       b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [3:0]       res,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0]       r_state;
    logic             r_win;       // doubles as last_winner for round-robin
    req_t             r_req;
    logic [3:0]       r_res;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic             w_pick;
    logic             w_cap;
    logic [3:0]       w_y;
    logic             w_ovf;

    // Winner selection; a lone requester always wins.
    always_comb begin
        w_any = req0 | req1;
        if (req0 && req1) w_pick = RR_EN ? ~r_win : 1'b0;
        else              w_pick = req1;
        w_cap = w_any && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    end

    alu_arbiter_alu u_alu (
        .i_op  (r_req.op),
        .i_a   (r_req.a),
        .i_b   (r_req.b),
        .o_y   (w_y),
        .o_ovf (w_ovf)
    );

    // Sequencer: capture, execute, respond (RESP may capture back-to-back).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: r_state <= w_any ? ST_EXEC : ST_IDLE;
                ST_EXEC:          r_state <= ST_RESP;
                default:          r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand/winner capture on every arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= 1'b1;
            r_req <= '0;
        end else if (w_cap) begin
            r_win <= w_pick;
            r_req <= w_pick ? req_t'({op1, a1, b1}) : req_t'({op0, a0, b0});
        end
    end

    // Result, flag and completion count register at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_EXEC) begin
            r_res <= w_y;
            r_err <= w_ovf & is_arith(r_req.op);
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign gnt0     = (r_state == ST_EXEC) & ~r_win;
    assign gnt1     = (r_state == ST_EXEC) &  r_win;
    assign done0    = (r_state == ST_RESP) & ~r_win;
    assign done1    = (r_state == ST_RESP) &  r_win;
    assign busy     = (r_state == ST_EXEC) | (r_state == ST_RESP);
    assign res      = r_res;
    assign err      = r_err;
    assign op_count = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (RR / fixed priority / 2-bit counter)
// share one stimulus and are checked each cycle against a transaction model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = '0, op1 = '0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic [2:0]      gnt0_o, gnt1_o, done0_o, done1_o, busy_o, err_o;
    logic [2:0][3:0] res_o;
    logic [7:0]      cnt0, cnt1;
    logic [1:0]      cnt2;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .done0(done0_o[0]), .done1(done1_o[0]),
        .res(res_o[0]), .err(err_o[0]), .busy(busy_o[0]), .op_count(cnt0));

    alu_arbiter #(.RR_EN(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .done0(done0_o[1]), .done1(done1_o[1]),
        .res(res_o[1]), .err(err_o[1]), .busy(busy_o[1]), .op_count(cnt1));

    alu_arbiter #(.RR_EN(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0_o[2]), .gnt1(gnt1_o[2]), .done0(done0_o[2]), .done1(done1_o[2]),
        .res(res_o[2]), .err(err_o[2]), .busy(busy_o[2]), .op_count(cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit rr_of(int k);
        return k != 1;
    endfunction

    function automatic int cmask(int k);
        return (k == 2) ? 3 : 255;
    endfunction

    // {err, res} from plain signed integer arithmetic.
    function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, r;
        logic [3:0] y;
        bit e;
        sa = (a > 7) ? int'(a) - 16 : int'(a);
        sb = (b > 7) ? int'(b) - 16 : int'(b);
        r = 0; e = 0; y = '0;
        case (op)
            2'b00: r = sa + sb;
            2'b01: r = sa - sb;
            default: r = 0;
        endcase
        if (op == 2'b00 || op == 2'b01) begin
            y = r[3:0];
            e = (r > 7) || (r < -8);
        end else if (op == 2'b10) begin
            y = ~(a & b);
        end else begin
            y = a ^ b;
        end
        return {e, y};
    endfunction

    // m_age: cycles since the current request was captured (0 = none pending).
    int         m_age [3];
    bit         m_win [3];
    logic [1:0] m_op  [3];
    logic [3:0] m_a   [3];
    logic [3:0] m_b   [3];
    logic [3:0] m_res [3];
    bit         m_err [3];
    int         m_cnt [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_age[k] = 0; m_win[k] = 1'b1; m_res[k] = '0;
                m_err[k] = 1'b0; m_cnt[k] = 0; m_op[k] = '0; m_a[k] = '0; m_b[k] = '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_age[k] == 1) begin
                    {m_err[k], m_res[k]} = alu_ref(m_op[k], m_a[k], m_b[k]);
                    m_cnt[k] = (m_cnt[k] + 1) & cmask(k);
                    m_age[k] = 2;
                end else if (req0 || req1) begin
                    if (req0 && req1) m_win[k] = rr_of(k) ? !m_win[k] : 1'b0;
                    else              m_win[k] = req1;
                    m_op[k] = m_win[k] ? op1 : op0;
                    m_a[k]  = m_win[k] ? a1 : a0;
                    m_b[k]  = m_win[k] ? b1 : b0;
                    m_age[k] = 1;
                end else begin
                    m_age[k] = 0;
                end
            end
        end
    end

    function automatic logic [31:0] dut_vec(int k);
        case (k)
            0: return {14'd0, gnt0_o[0], gnt1_o[0], done0_o[0], done1_o[0], busy_o[0], err_o[0], res_o[0], cnt0};
            1: return {14'd0, gnt0_o[1], gnt1_o[1], done0_o[1], done1_o[1], busy_o[1], err_o[1], res_o[1], cnt1};
            default: return {14'd0, gnt0_o[2], gnt1_o[2], done0_o[2], done1_o[2], busy_o[2], err_o[2], res_o[2], 6'd0, cnt2};
        endcase
    endfunction

    function automatic logic [31:0] model_vec(int k);
        bit g = (m_age[k] == 1);
        bit d = (m_age[k] == 2);
        return {14'd0, g && !m_win[k], g && m_win[k], d && !m_win[k], d && m_win[k],
                m_age[k] != 0, m_err[k], m_res[k], 8'(m_cnt[k])};
    endfunction

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            chk($sformatf("cycle u%0d", k), dut_vec(k), model_vec(k));
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_done = 0;
    endtask

    task automatic do_op(input int who, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic ee);
        int t;
        @(negedge clk);
        if (who == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!((who == 0) ? gnt0_o[0] : gnt1_o[0]) && t < 8);
        chk("gnt latency", t, 1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        n_done++;
        chk("done", (who == 0) ? done0_o[0] : done1_o[0], 1);
        chk("res", res_o[0], er);
        chk("err", err_o[0], ee);
        chk("op_count u0", cnt0, n_done);
        chk("op_count u2", cnt2, n_done % 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #12 rst_n = 1'b1;

        chk("reset busy", busy_o[0], 0);
        chk("reset cnt", cnt0, 0);

        do_op(0, OP_ADD, 4'h3, 4'h4, 4'h7, 1'b0);
        @(negedge clk);
        chk("busy after op", busy_o[0], 0);
        do_op(1, OP_ADD,  4'h7, 4'h1, 4'h8, 1'b1);
        do_op(1, OP_NAND, 4'hF, 4'hF, 4'h0, 1'b0);
        do_op(0, OP_SUB,  4'h8, 4'h1, 4'h7, 1'b1);
        do_op(1, OP_XOR,  4'hA, 4'h5, 4'hF, 1'b0);

        // Both requesters held: RR alternates, fixed priority starves requester 1.
        do_reset();
        @(negedge clk);
        req0 = 1'b1; op0 = OP_ADD; a0 = 4'h1; b0 = 4'h2;
        req1 = 1'b1; op1 = OP_SUB; a1 = 4'h9; b1 = 4'h3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                chk($sformatf("rr gnt0 #%0d", i / 2), gnt0_o[0], ((i / 2) % 2 == 0));
                chk($sformatf("rr gnt1 #%0d", i / 2), gnt1_o[0], ((i / 2) % 2 == 1));
                chk($sformatf("fixed gnt0 #%0d", i / 2), gnt0_o[1], 1);
            end else begin
                chk($sformatf("rr done0 #%0d", i / 2), done0_o[0], ((i / 2) % 2 == 0));
                chk($sformatf("fixed done1 #%0d", i / 2), done1_o[1], 0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during EXEC aborts the operation.
        do_reset();
        @(negedge clk);
        req0 = 1'b1; op0 = OP_ADD; a0 = 4'h5; b0 = 4'h6;
        @(negedge clk);
        chk("abort gnt0", gnt0_o[0], 1);
        #2 rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("abort res", res_o[0], 0);
        chk("abort busy", busy_o[0], 0);
        chk("abort gnt0 low", gnt0_o[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no done", done0_o[0], 0);
            chk("abort cnt", cnt0, 0);
        end

        // Randomized traffic, with occasional asynchronous reset pulses.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            req0 = ($urandom_range(0, 99) < 45);
            req1 = ($urandom_range(0, 99) < 45);
            op0 = 2'($urandom_range(0, 3)); a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
            op1 = 2'($urandom_range(0, 3)); a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
